// File: rtl/movx_bus_ctrl_if.sv
// Core-side request signals and multiplexed P0/P2 bus pins of the MOVX sequencer.
// The slave modport is the sequencer; the master modport is the core/board side.
interface movx_bus_ctrl_if;
    logic       start_rd;
    logic       start_wr;
    logic       use_dptr;
    logic [7:0] dptr_h;
    logic [7:0] dptr_l;
    logic [7:0] ri_addr;
    logic [7:0] p2_sfr;
    logic [7:0] wr_data;
    logic [7:0] p0_in;
    logic [7:0] p0_out;
    logic       p0_oe;
    logic [7:0] p2_out;
    logic       ale;
    logic       rd_n;
    logic       wr_n;
    logic [7:0] rd_data;
    logic       busy;
    logic       done;

    modport slave (
        input  start_rd, start_wr, use_dptr, dptr_h, dptr_l, ri_addr, p2_sfr,
               wr_data, p0_in,
        output p0_out, p0_oe, p2_out, ale, rd_n, wr_n, rd_data, busy, done
    );

    modport master (
        output start_rd, start_wr, use_dptr, dptr_h, dptr_l, ri_addr, p2_sfr,
               wr_data, p0_in,
        input  p0_out, p0_oe, p2_out, ale, rd_n, wr_n, rd_data, busy, done
    );
endinterface

// File: rtl/movx_bus_ctrl.sv
// External data-memory bus sequencer for MOVX: one ALE/RD_n/WR_n cycle on the
// multiplexed P0/P2 bus per request, read byte returned with a done pulse.
//
// state  | meaning
// IDLE   | waiting for start_rd/start_wr; P2 follows the SFR
// ADDR   | ale high, address driven on P0/P2
// LATCH  | ale low, address still on the bus
// STROBE | rd_n or wr_n low for STROBE_CYCLES cycles
// HOLD   | strobes released, done pulse, then back to IDLE
module movx_bus_ctrl #(
    parameter int unsigned STROBE_CYCLES = 3
) (
    input logic             clk_i,
    input logic             rst_n_i,
    movx_bus_ctrl_if.slave  bus_if
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        LATCH  = 3'd2,
        STROBE = 3'd3,
        HOLD   = 3'd4
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(STROBE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] addr_hi_q, addr_hi_d;
    logic [7:0] addr_lo_q, addr_lo_d;
    logic [7:0] wdat_q, wdat_d;
    logic       is_rd_q, is_rd_d;
    logic [7:0] rd_data_q, rd_data_d;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            addr_hi_q <= 8'h00;
            addr_lo_q <= 8'h00;
            wdat_q    <= 8'h00;
            is_rd_q   <= 1'b0;
            rd_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_hi_q <= addr_hi_d;
            addr_lo_q <= addr_lo_d;
            wdat_q    <= wdat_d;
            is_rd_q   <= is_rd_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_hi_d = addr_hi_q;
        addr_lo_d = addr_lo_q;
        wdat_d    = wdat_q;
        is_rd_d   = is_rd_q;
        rd_data_d = rd_data_q;

        bus_if.ale    = 1'b0;
        bus_if.rd_n   = 1'b1;
        bus_if.wr_n   = 1'b1;
        bus_if.p0_oe  = 1'b0;
        bus_if.p0_out = 8'hFF;
        bus_if.p2_out = addr_hi_q;
        bus_if.busy   = 1'b1;
        bus_if.done   = 1'b0;

        unique case (state_q)
            IDLE: begin
                bus_if.busy   = 1'b0;
                bus_if.p2_out = bus_if.p2_sfr;
                // Read wins when both requests arrive on the same edge.
                if (bus_if.start_rd || bus_if.start_wr) begin
                    state_d   = ADDR;
                    is_rd_d   = bus_if.start_rd;
                    addr_hi_d = bus_if.use_dptr ? bus_if.dptr_h : bus_if.p2_sfr;
                    addr_lo_d = bus_if.use_dptr ? bus_if.dptr_l : bus_if.ri_addr;
                    wdat_d    = bus_if.wr_data;
                    cnt_d     = 4'd0;
                end
            end
            ADDR: begin
                bus_if.ale    = 1'b1;
                bus_if.p0_oe  = 1'b1;
                bus_if.p0_out = addr_lo_q;
                state_d       = LATCH;
            end
            LATCH: begin
                bus_if.p0_oe  = 1'b1;
                bus_if.p0_out = addr_lo_q;
                state_d       = STROBE;
                cnt_d         = 4'd0;
            end
            STROBE: begin
                if (is_rd_q) begin
                    bus_if.rd_n = 1'b0;
                end else begin
                    bus_if.wr_n   = 1'b0;
                    bus_if.p0_oe  = 1'b1;
                    bus_if.p0_out = wdat_q;
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = HOLD;
                    cnt_d   = 4'd0;
                    if (is_rd_q) begin
                        rd_data_d = bus_if.p0_in;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            HOLD: begin
                bus_if.done = 1'b1;
                if (!is_rd_q) begin
                    bus_if.p0_oe  = 1'b1;
                    bus_if.p0_out = wdat_q;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus_if.rd_data = rd_data_q;

endmodule

// File: tb/tb_movx_bus_ctrl.sv
// Directed self-checking bench for movx_bus_ctrl with STROBE_CYCLES=3.
module tb_movx_bus_ctrl;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    movx_bus_ctrl_if bus();

    movx_bus_ctrl #(.STROBE_CYCLES(3)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus_if  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.start_rd = 1'b0;
        bus.start_wr = 1'b0;
        bus.use_dptr = 1'b1;
        bus.dptr_h   = 8'h00;
        bus.dptr_l   = 8'h00;
        bus.ri_addr  = 8'h00;
        bus.p2_sfr   = 8'h00;
        bus.wr_data  = 8'h00;
        bus.p0_in    = 8'h00;
    endtask

    task automatic test_reset();
        clear_inputs();
        bus.p2_sfr = 8'h5A;
        rst_n = 1'b0;
        #23;
        rst_n = 1'b1;
        tick();
        tests_run++;
        if (bus.ale !== 1'b0 || bus.rd_n !== 1'b1 || bus.wr_n !== 1'b1 || bus.p0_oe !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_strobes: ale=%b rd_n=%b wr_n=%b p0_oe=%b expected 0 1 1 0",
                     bus.ale, bus.rd_n, bus.wr_n, bus.p0_oe);
        end
        tests_run++;
        if (bus.p0_out !== 8'hFF || bus.rd_data !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_data: p0_out=%h rd_data=%h busy=%b done=%b expected FF 00 0 0",
                     bus.p0_out, bus.rd_data, bus.busy, bus.done);
        end
        tests_run++;
        if (bus.p2_out !== 8'h5A) begin
            tests_failed++;
            $display("FAIL reset_p2_follow: p2_out=%h expected 5A", bus.p2_out);
        end
        bus.p2_sfr = 8'hA7;
        #1;
        tests_run++;
        if (bus.p2_out !== 8'hA7) begin
            tests_failed++;
            $display("FAIL idle_p2_follow: p2_out=%h expected A7", bus.p2_out);
        end
    endtask

    task automatic test_dptr_read();
        int rd_low;
        int done_cnt;
        int done_at;
        int busy_cnt;
        int inv_bad;
        rd_low = 0; done_cnt = 0; done_at = -1; busy_cnt = 0; inv_bad = 0;
        bus.use_dptr = 1'b1;
        bus.dptr_h   = 8'h12;
        bus.dptr_l   = 8'h34;
        bus.p0_in    = 8'hC3;
        bus.start_rd = 1'b1;
        tick();
        bus.start_rd = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (c == 1) begin
                tests_run++;
                if (bus.ale !== 1'b1 || bus.p0_out !== 8'h34 || bus.p2_out !== 8'h12 || bus.p0_oe !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL read_addr_phase: ale=%b p0_out=%h p2_out=%h p0_oe=%b expected 1 34 12 1",
                             bus.ale, bus.p0_out, bus.p2_out, bus.p0_oe);
                end
            end
            if (bus.rd_n === 1'b0) rd_low++;
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            if ((bus.rd_n === 1'b0 && (bus.p0_oe !== 1'b0 || bus.ale !== 1'b0 || bus.wr_n !== 1'b1)))
                inv_bad++;
            tick();
        end
        tests_run++;
        if (rd_low != 3) begin
            tests_failed++;
            $display("FAIL read_strobe_len: rd_n low %0d cycles expected 3", rd_low);
        end
        tests_run++;
        if (done_cnt != 1 || done_at != 6) begin
            tests_failed++;
            $display("FAIL read_done: done count %0d at cycle %0d expected 1 at 6", done_cnt, done_at);
        end
        tests_run++;
        if (busy_cnt != 6) begin
            tests_failed++;
            $display("FAIL read_busy_len: busy %0d cycles expected 6", busy_cnt);
        end
        tests_run++;
        if (bus.rd_data !== 8'hC3 || inv_bad != 0) begin
            tests_failed++;
            $display("FAIL read_data: rd_data=%h inv_bad=%0d expected C3 0", bus.rd_data, inv_bad);
        end
    endtask

    task automatic test_ri_write();
        int wr_low;
        int bad_data;
        int hold_bad;
        int done_cnt;
        wr_low = 0; bad_data = 0; hold_bad = 0; done_cnt = 0;
        bus.use_dptr = 1'b0;
        bus.p2_sfr   = 8'h80;
        bus.ri_addr  = 8'h41;
        bus.wr_data  = 8'h9E;
        bus.p0_in    = 8'h55;
        bus.start_wr = 1'b1;
        tick();
        bus.start_wr = 1'b0;
        tests_run++;
        if (bus.ale !== 1'b1 || bus.p0_out !== 8'h41 || bus.p2_out !== 8'h80) begin
            tests_failed++;
            $display("FAIL write_addr_phase: ale=%b p0_out=%h p2_out=%h expected 1 41 80",
                     bus.ale, bus.p0_out, bus.p2_out);
        end
        for (int c = 1; c <= 10; c++) begin
            if (bus.wr_n === 1'b0) begin
                wr_low++;
                if (bus.p0_out !== 8'h9E || bus.p0_oe !== 1'b1 || bus.p2_out !== 8'h80 || bus.rd_n !== 1'b1)
                    bad_data++;
            end
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (bus.p0_out !== 8'h9E || bus.p0_oe !== 1'b1 || bus.wr_n !== 1'b1)
                    hold_bad++;
            end
            tick();
        end
        tests_run++;
        if (wr_low != 3 || bad_data != 0) begin
            tests_failed++;
            $display("FAIL write_strobe: wr_n low %0d cycles, %0d bad, expected 3 and 0", wr_low, bad_data);
        end
        tests_run++;
        if (done_cnt != 1 || hold_bad != 0) begin
            tests_failed++;
            $display("FAIL write_hold: done %0d, hold_bad %0d expected 1 and 0", done_cnt, hold_bad);
        end
        tests_run++;
        if (bus.rd_data !== 8'hC3) begin
            tests_failed++;
            $display("FAIL write_keeps_rd_data: rd_data=%h expected C3", bus.rd_data);
        end
    endtask

    task automatic test_arbitration();
        int rd_low;
        int wr_low;
        int done_cnt;
        rd_low = 0; wr_low = 0; done_cnt = 0;
        bus.use_dptr = 1'b1;
        bus.dptr_h   = 8'h20;
        bus.dptr_l   = 8'h01;
        bus.p0_in    = 8'h6B;
        bus.start_rd = 1'b1;
        bus.start_wr = 1'b1;
        tick();
        bus.start_rd = 1'b0;
        bus.start_wr = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (bus.rd_n === 1'b0) rd_low++;
            if (bus.wr_n === 1'b0) wr_low++;
            if (bus.done === 1'b1) done_cnt++;
            tick();
        end
        tests_run++;
        if (rd_low != 3 || wr_low != 0 || done_cnt != 1 || bus.rd_data !== 8'h6B) begin
            tests_failed++;
            $display("FAIL both_starts: rd_low=%0d wr_low=%0d done=%0d rd_data=%h expected 3 0 1 6B",
                     rd_low, wr_low, done_cnt, bus.rd_data);
        end
        rd_low = 0; wr_low = 0; done_cnt = 0;
        bus.p0_in    = 8'h17;
        bus.start_rd = 1'b1;
        tick();
        bus.start_rd = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            bus.start_wr = (c == 3);
            if (bus.rd_n === 1'b0) rd_low++;
            if (bus.wr_n === 1'b0) wr_low++;
            if (bus.done === 1'b1) done_cnt++;
            tick();
        end
        bus.start_wr = 1'b0;
        tests_run++;
        if (rd_low != 3 || wr_low != 0 || done_cnt != 1 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_ignores_start: rd_low=%0d wr_low=%0d done=%0d busy=%b expected 3 0 1 0",
                     rd_low, wr_low, done_cnt, bus.busy);
        end
    endtask

    task automatic test_operand_stability();
        int addr_bad;
        int p2_bad;
        addr_bad = 0; p2_bad = 0;
        bus.use_dptr = 1'b1;
        bus.dptr_h   = 8'h12;
        bus.dptr_l   = 8'h34;
        bus.p2_sfr   = 8'h00;
        bus.p0_in    = 8'h3C;
        bus.start_rd = 1'b1;
        tick();
        bus.start_rd = 1'b0;
        bus.dptr_h   = 8'hFF;
        bus.dptr_l   = 8'hFF;
        for (int c = 1; c <= 8; c++) begin
            if (c <= 2 && bus.p0_out !== 8'h34) addr_bad++;
            if (c <= 6 && bus.p2_out !== 8'h12) p2_bad++;
            tick();
        end
        tests_run++;
        if (addr_bad != 0 || p2_bad != 0 || bus.rd_data !== 8'h3C) begin
            tests_failed++;
            $display("FAIL operand_stable: addr_bad=%0d p2_bad=%0d rd_data=%h expected 0 0 3C",
                     addr_bad, p2_bad, bus.rd_data);
        end
    endtask

    task automatic test_reset_mid_strobe();
        int done_cnt;
        done_cnt = 0;
        bus.dptr_h   = 8'h44;
        bus.dptr_l   = 8'h55;
        bus.p0_in    = 8'hEE;
        bus.start_rd = 1'b1;
        tick();
        bus.start_rd = 1'b0;
        tick();
        tick();
        tests_run++;
        if (bus.rd_n !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_setup: rd_n=%b expected 0 in strobe", bus.rd_n);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.rd_n !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.rd_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL abort_async: rd_n=%b busy=%b done=%b rd_data=%h expected 1 0 0 00",
                     bus.rd_n, bus.busy, bus.done, bus.rd_data);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (bus.done === 1'b1) done_cnt++;
            tick();
        end
        tests_run++;
        if (done_cnt != 0 || bus.rd_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL abort_no_done: done=%0d rd_data=%h expected 0 00", done_cnt, bus.rd_data);
        end
        done_cnt = 0;
        bus.p0_in    = 8'hA5;
        bus.start_rd = 1'b1;
        tick();
        bus.start_rd = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (bus.done === 1'b1) done_cnt++;
            tick();
        end
        tests_run++;
        if (done_cnt != 1 || bus.rd_data !== 8'hA5) begin
            tests_failed++;
            $display("FAIL read_after_abort: done=%0d rd_data=%h expected 1 A5", done_cnt, bus.rd_data);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        clear_inputs();
        test_reset();
        test_dptr_read();
        test_ri_write();
        test_arbitration();
        test_operand_stability();
        test_reset_mid_strobe();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
